sal_timing_cnt: RTL



---
 rtl/sal_timing_cnt_pkg.sv | 35 +++
 rtl/sal_timing_cnt_tcnt.sv | 29 ++
 rtl/sal_timing_cnt.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sal_timing_cnt_pkg.sv
// rtl/sal_timing_cnt_pkg.sv - shared DDR2 command type, default timings and helpers
package sal_timing_cnt_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } dram_cmd_t;

    localparam int DEF_BK_CNT = 4;
    localparam int DEF_CNT_W  = 5;
    localparam int DEF_T_RCD  = 4;
    localparam int DEF_T_RP   = 4;
    localparam int DEF_T_RAS  = 12;
    localparam int DEF_T_RC   = 16;
    localparam int DEF_T_RRD  = 3;
    localparam int DEF_T_CCD  = 2;
    localparam int DEF_T_RTP  = 3;
    localparam int DEF_T_WR   = 10;
    localparam int DEF_T_WTR  = 8;
    localparam int DEF_T_RTW  = 5;
    localparam int DEF_T_RFC  = 26;

    typedef logic [$clog2(DEF_BK_CNT)-1:0] bank_idx_t;

    // A constraint of N cycles means the counter must hold N-1 after the
    // issuing edge so the flag returns exactly N cycles later; 0 acts as 1.
    function automatic int load_of(input int n);
        return (n <= 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/sal_timing_cnt_tcnt.sv
// rtl/sal_timing_cnt_tcnt.sv - saturating down-counter with max-load and zero flag
module sal_tcnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] dec;

    assign dec  = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    assign zero = (cnt == '0);

    // Count down to zero; a load only takes effect when it raises the value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load_en && (load_val > dec)) begin
            cnt <= load_val;
        end else begin
            cnt <= dec;
        end
    end

endmodule

// File: rtl/sal_timing_cnt.sv
// rtl/sal_timing_cnt.sv - DDR2 command-timing tracker producing per-bank allowed flags
module sal_timing_cnt
    import sal_timing_cnt_pkg::*;
#(
    parameter int BK_CNT = DEF_BK_CNT,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RAS  = DEF_T_RAS,
    parameter int T_RC   = DEF_T_RC,
    parameter int T_RRD  = DEF_T_RRD,
    parameter int T_CCD  = DEF_T_CCD,
    parameter int T_RTP  = DEF_T_RTP,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_WTR  = DEF_T_WTR,
    parameter int T_RTW  = DEF_T_RTW,
    parameter int T_RFC  = DEF_T_RFC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  dram_cmd_t                 cmd,
    input  logic [$clog2(BK_CNT)-1:0] cmd_ba,
    output logic [BK_CNT-1:0]         act_ok,
    output logic [BK_CNT-1:0]         rd_ok,
    output logic [BK_CNT-1:0]         wr_ok,
    output logic [BK_CNT-1:0]         pre_ok,
    output logic                      ref_ok,
    output logic                      timing_viol
);

    localparam int BA_W = $clog2(BK_CNT);

    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(load_of(T_RCD));
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(load_of(T_RP));
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(load_of(T_RAS));
    localparam logic [CNT_W-1:0] LD_RC  = CNT_W'(load_of(T_RC));
    localparam logic [CNT_W-1:0] LD_RRD = CNT_W'(load_of(T_RRD));
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(load_of(T_CCD));
    localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(load_of(T_RTP));
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(load_of(T_WR));
    localparam logic [CNT_W-1:0] LD_WTR = CNT_W'(load_of(T_WTR));
    localparam logic [CNT_W-1:0] LD_RTW = CNT_W'(load_of(T_RTW));
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(load_of(T_RFC));

    function automatic logic [CNT_W-1:0] cnt_max(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic is_act, is_rd, is_wr, is_pre, is_ref;

    assign is_act = cmd_valid && (cmd == CMD_ACT);
    assign is_rd  = cmd_valid && (cmd == CMD_RD);
    assign is_wr  = cmd_valid && (cmd == CMD_WR);
    assign is_pre = cmd_valid && (cmd == CMD_PRE);
    assign is_ref = cmd_valid && (cmd == CMD_REF);

    logic [BK_CNT-1:0] act_ld_en, rd_ld_en, wr_ld_en, pre_ld_en;
    logic [CNT_W-1:0]  act_ld_val [BK_CNT];
    logic [CNT_W-1:0]  rd_ld_val  [BK_CNT];
    logic [CNT_W-1:0]  wr_ld_val  [BK_CNT];
    logic [CNT_W-1:0]  pre_ld_val [BK_CNT];
    logic              ref_ld_en;
    logic [CNT_W-1:0]  ref_ld_val;

    // Per-bank load selection: every constraint touching a counter this cycle
    // contributes, and the largest remaining wait is the one loaded.
    always_comb begin
        for (int b = 0; b < BK_CNT; b++) begin
            logic sel;
            sel           = (cmd_ba == BA_W'(b));
            act_ld_en[b]  = 1'b0;
            rd_ld_en[b]   = 1'b0;
            wr_ld_en[b]   = 1'b0;
            pre_ld_en[b]  = 1'b0;
            act_ld_val[b] = '0;
            rd_ld_val[b]  = '0;
            wr_ld_val[b]  = '0;
            pre_ld_val[b] = '0;

            if (is_act) begin
                act_ld_en[b]  = 1'b1;
                act_ld_val[b] = cnt_max(act_ld_val[b], LD_RRD);
                if (sel) begin
                    act_ld_val[b] = cnt_max(act_ld_val[b], LD_RC);
                    rd_ld_en[b]   = 1'b1;
                    rd_ld_val[b]  = cnt_max(rd_ld_val[b], LD_RCD);
                    wr_ld_en[b]   = 1'b1;
                    wr_ld_val[b]  = cnt_max(wr_ld_val[b], LD_RCD);
                    pre_ld_en[b]  = 1'b1;
                    pre_ld_val[b] = cnt_max(pre_ld_val[b], LD_RAS);
                end
            end

            if (is_rd) begin
                rd_ld_en[b]  = 1'b1;
                rd_ld_val[b] = cnt_max(rd_ld_val[b], LD_CCD);
                wr_ld_en[b]  = 1'b1;
                wr_ld_val[b] = cnt_max(wr_ld_val[b], LD_RTW);
                if (sel) begin
                    pre_ld_en[b]  = 1'b1;
                    pre_ld_val[b] = cnt_max(pre_ld_val[b], LD_RTP);
                end
            end

            if (is_wr) begin
                wr_ld_en[b]  = 1'b1;
                wr_ld_val[b] = cnt_max(wr_ld_val[b], LD_CCD);
                rd_ld_en[b]  = 1'b1;
                rd_ld_val[b] = cnt_max(rd_ld_val[b], LD_WTR);
                if (sel) begin
                    pre_ld_en[b]  = 1'b1;
                    pre_ld_val[b] = cnt_max(pre_ld_val[b], LD_WR);
                end
            end

            if (is_pre && sel) begin
                act_ld_en[b]  = 1'b1;
                act_ld_val[b] = cnt_max(act_ld_val[b], LD_RP);
            end

            if (is_ref) begin
                act_ld_en[b]  = 1'b1;
                act_ld_val[b] = cnt_max(act_ld_val[b], LD_RFC);
            end
        end
    end

    // Global refresh counter: guarded by any PRE and by the previous REF.
    always_comb begin
        ref_ld_en  = 1'b0;
        ref_ld_val = '0;
        if (is_pre) begin
            ref_ld_en  = 1'b1;
            ref_ld_val = cnt_max(ref_ld_val, LD_RP);
        end
        if (is_ref) begin
            ref_ld_en  = 1'b1;
            ref_ld_val = cnt_max(ref_ld_val, LD_RFC);
        end
    end

    for (genvar g = 0; g < BK_CNT; g++) begin : g_bank
        logic [CNT_W-1:0] act_cnt, rd_cnt, wr_cnt, pre_cnt;

        sal_tcnt #(.CNT_W(CNT_W)) u_act (
            .clk      (clk),
            .rst      (rst),
            .load_en  (act_ld_en[g]),
            .load_val (act_ld_val[g]),
            .cnt      (act_cnt),
            .zero     (act_ok[g])
        );

        sal_tcnt #(.CNT_W(CNT_W)) u_rd (
            .clk      (clk),
            .rst      (rst),
            .load_en  (rd_ld_en[g]),
            .load_val (rd_ld_val[g]),
            .cnt      (rd_cnt),
            .zero     (rd_ok[g])
        );

        sal_tcnt #(.CNT_W(CNT_W)) u_wr (
            .clk      (clk),
            .rst      (rst),
            .load_en  (wr_ld_en[g]),
            .load_val (wr_ld_val[g]),
            .cnt      (wr_cnt),
            .zero     (wr_ok[g])
        );

        sal_tcnt #(.CNT_W(CNT_W)) u_pre (
            .clk      (clk),
            .rst      (rst),
            .load_en  (pre_ld_en[g]),
            .load_val (pre_ld_val[g]),
            .cnt      (pre_cnt),
            .zero     (pre_ok[g])
        );
    end

    logic [CNT_W-1:0] ref_cnt;

    sal_tcnt #(.CNT_W(CNT_W)) u_ref (
        .clk      (clk),
        .rst      (rst),
        .load_en  (ref_ld_en),
        .load_val (ref_ld_val),
        .cnt      (ref_cnt),
        .zero     (ref_ok)
    );

    logic cmd_allowed;

    // Look up the allowed flag that matches the command being issued now.
    always_comb begin
        cmd_allowed = 1'b1;
        case (cmd)
            CMD_ACT: cmd_allowed = act_ok[cmd_ba];
            CMD_RD:  cmd_allowed = rd_ok[cmd_ba];
            CMD_WR:  cmd_allowed = wr_ok[cmd_ba];
            CMD_PRE: cmd_allowed = pre_ok[cmd_ba];
            CMD_REF: cmd_allowed = ref_ok;
            default: cmd_allowed = 1'b1;
        endcase
    end

    // Flag, one cycle later, any command issued while its flag was low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timing_viol <= 1'b0;
        end else begin
            timing_viol <= cmd_valid && (cmd != CMD_NOP) && !cmd_allowed;
        end
    end

endmodule
